pkt_switch_n: RTL and testbench

Parametrised successor of the 4-port router. It accepts byte-serial packets on one input, routes each packet by its header byte to one of NUM_PORTS output FIFOs, and applies input back-pressure through an explicit busy output. A runtime-programmable address table maps header values to ports. Packets whose header matches no table entry are dropped and counted. It sits between the packet source and the per-port consumers.

---
 rtl/pkt_switch_n_if.sv | 31 +++
 rtl/pkt_switch_n.sv | 200 ++++++++++++++++++++
 tb/tb_pkt_switch_n.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_switch_n_if.sv
// rtl/pkt_switch_n_if.sv - packet input, table access and per-port output bundle for pkt_switch_n
interface pkt_switch_n_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8
);
    localparam int AW = $clog2(NUM_PORTS);

    logic                          data_status;
    logic [DATA_W-1:0]             data;
    logic                          busy;
    logic                          mem_en;
    logic                          mem_rd_wr;
    logic [AW-1:0]                 mem_add;
    logic [DATA_W-1:0]             mem_data;
    logic [NUM_PORTS*DATA_W-1:0]   port_data;
    logic [NUM_PORTS-1:0]          ready;
    logic [NUM_PORTS-1:0]          read;
    logic [CNT_W-1:0]              drop_cnt;
    logic [CNT_W-1:0]              parity_err_cnt;

    modport slave (
        input  data_status, data, mem_en, mem_rd_wr, mem_add, mem_data, read,
        output busy, port_data, ready, drop_cnt, parity_err_cnt
    );

    modport master (
        output data_status, data, mem_en, mem_rd_wr, mem_add, mem_data, read,
        input  busy, port_data, ready, drop_cnt, parity_err_cnt
    );
endinterface

// File: rtl/pkt_switch_n.sv
// rtl/pkt_switch_n.sv - header-routed packet switch into NUM_PORTS FIFOs; PKT_PARITY_CHECK_EN adds parity checking
module pkt_switch_n #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    pkt_switch_n_if.slave bus
);
    localparam int AW = $clog2(NUM_PORTS);
    localparam int PW = $clog2(FIFO_DEPTH);

`ifdef PKT_PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, DATA, DROP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
`endif

    state_t              state_q, state_d;
    logic [AW-1:0]       dest_q, dest_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [DATA_W-1:0]   tbl_q [NUM_PORTS];
    logic [PW:0]         wptr_q [NUM_PORTS];
    logic [PW:0]         rptr_q [NUM_PORTS];
    logic [DATA_W-1:0]   mem_q [NUM_PORTS][FIFO_DEPTH];
    logic [DATA_W-1:0]   pdata_q [NUM_PORTS];
`ifdef PKT_PARITY_CHECK_EN
    logic [DATA_W-1:0]   par_q, par_d;
    logic [DATA_W-1:0]   pbyte_q, pbyte_d;
    logic [CNT_W-1:0]    perr_q, perr_d;
`endif

    logic [NUM_PORTS-1:0] full, empty, pop;
    logic                 hit;
    logic [AW-1:0]        hit_idx;
    logic                 wr_en;
    logic [AW-1:0]        wr_port;
    logic [DATA_W-1:0]    wr_byte;
    logic                 busy;

    // Full compares against the pre-read pointer, so a same-edge read does not unblock a write.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i] == {~rptr_q[i][PW], rptr_q[i][PW-1:0]});
            pop[i]   = bus.read[i] & ~empty[i];
        end
    end

    // Descending scan so the lowest matching index wins on duplicate entries.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (tbl_q[k] == bus.data) begin
                hit     = 1'b1;
                hit_idx = AW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        wr_port = dest_q;
        wr_byte = bus.data;
        busy    = 1'b0;
`ifdef PKT_PARITY_CHECK_EN
        par_d   = par_q;
        pbyte_d = pbyte_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.data_status) begin
                    if (hit) begin
                        wr_port = hit_idx;
                        if (full[hit_idx]) begin
                            busy = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            dest_d  = hit_idx;
                            state_d = DATA;
`ifdef PKT_PARITY_CHECK_EN
                            par_d   = bus.data;
`endif
                        end
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            DATA: begin
                if (bus.data_status) begin
                    if (full[dest_q]) begin
                        busy = 1'b1;
                    end else begin
                        wr_en = 1'b1;
`ifdef PKT_PARITY_CHECK_EN
                        par_d = par_q ^ bus.data;
`endif
                    end
                end else begin
`ifdef PKT_PARITY_CHECK_EN
                    pbyte_d = bus.data;
                    state_d = PARITY;
`else
                    if (full[dest_q]) begin
                        busy = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef PKT_PARITY_CHECK_EN
            PARITY: begin
                busy    = 1'b1;
                wr_byte = (pbyte_q == par_q) ? pbyte_q
                                             : (pbyte_q ^ {1'b1, {(DATA_W-1){1'b0}}});
                if (!full[dest_q]) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                    if (pbyte_q != par_q && perr_q != {CNT_W{1'b1}})
                        perr_d = perr_q + 1'b1;
                end
            end
`endif
            DROP: begin
                if (!bus.data_status) begin
                    state_d = IDLE;
                    if (drop_q != {CNT_W{1'b1}})
                        drop_d = drop_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            drop_q  <= '0;
`ifdef PKT_PARITY_CHECK_EN
            par_q   <= '0;
            pbyte_q <= '0;
            perr_q  <= '0;
`endif
            for (int i = 0; i < NUM_PORTS; i++) begin
                tbl_q[i]   <= DATA_W'(i);
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                pdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            drop_q  <= drop_d;
`ifdef PKT_PARITY_CHECK_EN
            par_q   <= par_d;
            pbyte_q <= pbyte_d;
            perr_q  <= perr_d;
`endif
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (wr_en && wr_port == AW'(i))
                    wptr_q[i] <= wptr_q[i] + (PW+1)'(1);
                if (pop[i]) begin
                    rptr_q[i]  <= rptr_q[i] + (PW+1)'(1);
                    pdata_q[i] <= mem_q[i][rptr_q[i][PW-1:0]];
                end
            end
            if (bus.mem_en && bus.mem_rd_wr)
                tbl_q[bus.mem_add] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_port][wptr_q[wr_port][PW-1:0]] <= wr_byte;
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign bus.port_data[g*DATA_W +: DATA_W] = pdata_q[g];
    end

    assign bus.ready    = ~empty;
    assign bus.busy     = busy;
    assign bus.drop_cnt = drop_q;
`ifdef PKT_PARITY_CHECK_EN
    assign bus.parity_err_cnt = perr_q;
`else
    assign bus.parity_err_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_switch_n.sv
// tb/tb_pkt_switch_n.sv - randomized self-checking bench for pkt_switch_n against a queue-based packet model
module tb_pkt_switch_n;
    localparam int NP = 4, DW = 8, DEPTH = 16, CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pkt_switch_n_if #(.NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) ifc ();

    pkt_switch_n #(.NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef logic [7:0] bq_t[$];

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] mq [NP][$];
    logic [7:0] mtbl [NP];
    int         mdrop = 0;
    int         mperr = 0;
    bq_t        pl;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            mtbl[i] = 8'(i);
        end
        mdrop = 0;
        mperr = 0;
    endtask

    function automatic int lookup(logic [7:0] hdr);
        int d = -1;
        for (int k = NP - 1; k >= 0; k--)
            if (mtbl[k] == hdr) d = k;
        return d;
    endfunction

    task automatic send_byte(logic ds, logic [7:0] d);
        int  n = 0;
        logic b;
        @(negedge clk);
        ifc.data_status = ds;
        ifc.data = d;
        while (1) begin
            #4;
            b = ifc.busy;
            @(posedge clk);
            if (!b) break;
            n++;
            if (n > 300) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Model is updated before the bytes go out so a concurrent reader sees the expected order.
    task automatic send_pkt(logic [7:0] hdr, bq_t p, logic [7:0] perr_xor);
        logic [7:0] par = hdr;
        logic [7:0] pb;
        int dst;
        foreach (p[i]) par ^= p[i];
        pb  = par ^ perr_xor;
        dst = lookup(hdr);
        if (dst < 0) begin
            mdrop++;
        end else begin
            mq[dst].push_back(hdr);
            foreach (p[i]) mq[dst].push_back(p[i]);
`ifdef PKT_PARITY_CHECK_EN
            if (pb != par) begin
                mperr++;
                mq[dst].push_back(pb ^ 8'h80);
            end else begin
                mq[dst].push_back(pb);
            end
`else
            mq[dst].push_back(pb);
`endif
        end
        send_byte(1'b1, hdr);
        foreach (p[i]) send_byte(1'b1, p[i]);
        send_byte(1'b0, pb);
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_check(int p);
        int n = 0;
        logic [7:0] exp;
        @(negedge clk);
        while (!ifc.ready[p] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.ready[p]) begin
            check("pop_timeout", 32'd0, 32'd1);
            return;
        end
        ifc.read[p] = 1'b1;
        @(posedge clk);
        #1;
        ifc.read[p] = 1'b0;
        exp = (mq[p].size() > 0) ? mq[p].pop_front() : 8'hxx;
        check($sformatf("port_data[%0d]", p), 32'(ifc.port_data[p*DW +: DW]), 32'(exp));
    endtask

    task automatic drain(int p);
        while (mq[p].size() > 0) pop_check(p);
    endtask

    task automatic tbl_write(int idx, logic [7:0] val);
        @(negedge clk);
        ifc.mem_en = 1'b1;
        ifc.mem_rd_wr = 1'b1;
        ifc.mem_add = 2'(idx);
        ifc.mem_data = val;
        @(posedge clk);
        #1;
        ifc.mem_en = 1'b0;
        ifc.mem_rd_wr = 1'b0;
        mtbl[idx] = val;
    endtask

    task automatic make_pl(int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        ifc.data_status = 1'b0;
        ifc.data = '0;
        ifc.mem_en = 1'b0;
        ifc.mem_rd_wr = 1'b0;
        ifc.mem_add = '0;
        ifc.mem_data = '0;
        ifc.read = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ifc.ready), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_port_data", ifc.port_data, 32'd0);
        check("rst_drop", 32'(ifc.drop_cnt), 32'd0);
        check("rst_perr", 32'(ifc.parity_err_cnt), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // basic routing to port 2
        pl.delete(); pl.push_back(8'hA5); pl.push_back(8'h3C);
        send_pkt(8'h02, pl, 8'h00);
        check("t1_ready", 32'(ifc.ready), 32'h4);
        check("t1_depth", mq[2].size(), 4);
        drain(2);
        check("t1_ready_empty", 32'(ifc.ready), 32'h0);

        // table remap and drop
        tbl_write(1, 8'h55);
        make_pl(3);
        send_pkt(8'h55, pl, 8'h00);
        check("t2_ready", 32'(ifc.ready), 32'h2);
        make_pl(2);
        send_pkt(8'h01, pl, 8'h00);
        check("t2_drop", 32'(ifc.drop_cnt), 32'(mdrop));
        check("t2_drop_one", 32'(ifc.drop_cnt), 32'd1);
        check("t2_ready_nochg", 32'(ifc.ready), 32'h2);
        drain(1);

        // back-pressure: FIFO 3 at DEPTH-1, then a short packet
        make_pl(DEPTH - 3);
        send_pkt(8'h03, pl, 8'h00);
        check("t3_fill", mq[3].size(), DEPTH - 1);
        make_pl(2);
        fork
            send_pkt(8'h03, pl, 8'h00);
            begin
                repeat (6) @(negedge clk);
                #4;
                check("t3_busy", 32'(ifc.busy), 32'd1);
                repeat (DEPTH - 1 + 4) pop_check(3);
            end
        join
        check("t3_ready_empty", 32'(ifc.ready), 32'h0);

        // concurrent write and read across pointer wrap on a full FIFO
        make_pl(DEPTH - 2);
        send_pkt(8'h00, pl, 8'h00);
        check("t4_full_ready", 32'(ifc.ready), 32'h1);
        make_pl(38);
        fork
            send_pkt(8'h00, pl, 8'h00);
            repeat (DEPTH + 40) pop_check(0);
        join
        check("t4_ready_empty", 32'(ifc.ready), 32'h0);

        // wrong parity: correct value is 0x11, 0x10 is sent
        pl.delete(); pl.push_back(8'h11);
        send_pkt(8'h00, pl, 8'h01);
        check("t5_perr", 32'(ifc.parity_err_cnt), 32'(mperr));
        drain(0);

        // reset in the middle of a payload
        send_byte(1'b1, 8'h02);
        send_byte(1'b1, 8'hAA);
        @(negedge clk);
        reset = 1'b0;
        ifc.data_status = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("t6_ready", 32'(ifc.ready), 32'h0);
        check("t6_busy", 32'(ifc.busy), 32'd0);
        check("t6_drop", 32'(ifc.drop_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        make_pl(2);
        send_pkt(8'h00, pl, 8'h00);
        check("t6_route", 32'(ifc.ready), 32'h1);
        drain(0);

        // randomized traffic with table rewrites, drops and parity errors
        for (int it = 0; it < 60; it++) begin
            int hdr, len, dst;
            logic [7:0] px;
            if ($urandom_range(0, 3) == 0)
                tbl_write($urandom_range(0, NP - 1), 8'($urandom_range(0, 9)));
            hdr = $urandom_range(0, 9);
            len = $urandom_range(0, 4);
            px  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            dst = lookup(8'(hdr));
            if (dst >= 0 && mq[dst].size() + len + 2 > DEPTH) drain(dst);
            make_pl(len);
            send_pkt(8'(hdr), pl, px);
            if ($urandom_range(0, 5) == 0) drain($urandom_range(0, NP - 1));
        end
        for (int p = 0; p < NP; p++) drain(p);
        check("rnd_ready", 32'(ifc.ready), 32'h0);
        check("rnd_drop", 32'(ifc.drop_cnt), 32'(mdrop));
        check("rnd_perr", 32'(ifc.parity_err_cnt), 32'(mperr));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
